// File: rtl/fft_pkg.sv
// Shared FFT datapath definitions: widths, loader state encoding and the
// frame-size clamp used when a new frame is armed.
package fft_pkg;

  localparam int FFT_ADDR_W   = 12;
  localparam int FFT_SAMPLE_W = 16;
  localparam int FFT_LOG2_W   = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    FLUSH   = 2'd2,
    COMPUTE = 2'd3
  } loader_state_t;

  // A zero exponent still means a two-point frame; anything above the RAM
  // depth is pinned to the full RAM.
  function automatic logic [FFT_LOG2_W-1:0] clamp_log2n(
    input logic [FFT_LOG2_W-1:0] value,
    input int                    max_n
  );
    if (value == '0) begin
      return FFT_LOG2_W'(1);
    end
    if (int'(value) > max_n) begin
      return FFT_LOG2_W'(max_n);
    end
    return value;
  endfunction

endpackage

// File: rtl/fft_input_loader_if.sv
// Sample stream into the FFT loader: payload, valid/ready handshake and the
// producer's end-of-frame marker.
interface fft_input_loader_if #(
  parameter int DATA_W = 16
);

  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic              s_last;

  modport master (
    output s_data,
    output s_valid,
    output s_last,
    input  s_ready
  );

  modport slave (
    input  s_data,
    input  s_valid,
    input  s_last,
    output s_ready
  );

endinterface

// File: rtl/fft_input_loader_bit_rev.sv
// Combinational bit-reversed address generator: reverses the low n bits of
// the sample count and leaves the upper address bits at zero.
module bit_rev #(
  parameter int ADDR_W = 12,
  parameter int N_W    = $clog2(ADDR_W + 1)
) (
  input  logic [ADDR_W-1:0] count,
  input  logic [N_W-1:0]    n,
  output logic [ADDR_W-1:0] adr
);

  logic [ADDR_W-1:0] full_rev;
  logic [N_W-1:0]    shift;

  // Reversing the whole word and shifting down drops the unused upper count
  // bits and lands the n reversed bits at the bottom.
  always_comb begin
    full_rev = '0;
    for (int i = 0; i < ADDR_W; i++) begin
      full_rev[i] = count[ADDR_W-1-i];
    end
    shift = N_W'(ADDR_W) - n;
    adr   = full_rev >> shift;
  end

endmodule

// File: rtl/fft_input_loader.sv
// FFT input loader: accepts a frame of samples over a valid/ready stream and
// writes them to the sample RAM in bit-reversed order, then hands the RAM over.
module fft_input_loader
  import fft_pkg::*;
#(
  parameter int ADDR_W = FFT_ADDR_W,
  parameter int DATA_W = FFT_SAMPLE_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [FFT_LOG2_W-1:0] log2n,
  fft_input_loader_if.slave     s,
  output logic [DATA_W-1:0]     ram_data,
  output logic [ADDR_W-1:0]     ram_adr,
  output logic                  ram_write,
  output logic                  mode,
  input  logic                  compute_done,
  output logic                  frame_done,
  output logic                  err_last
);

  localparam int N_W = $clog2(ADDR_W + 1);

  loader_state_t     state;
  loader_state_t     next_state;
  logic [ADDR_W-1:0] k;
  logic [N_W-1:0]    n_q;
  logic [ADDR_W-1:0] last_k;
  logic [ADDR_W-1:0] rev_adr;
  logic              s_ready_q;
  logic              handshake;
  logic              last_beat;
  logic              start_accept;

  assign s.s_ready    = s_ready_q;
  assign handshake    = s.s_valid & s_ready_q;
  assign start_accept = (state == IDLE) & start;
  // N-1 is an all-ones mask of the low n bits.
  assign last_k       = {ADDR_W{1'b1}} >> (N_W'(ADDR_W) - n_q);
  assign last_beat    = (k == last_k);

  bit_rev #(
    .ADDR_W (ADDR_W),
    .N_W    (N_W)
  ) u_bit_rev (
    .count (k),
    .n     (n_q),
    .adr   (rev_adr)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // NOTE: every variable written here gets a default first, so no path
  // through the case can leave a value held and infer a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (start)                  next_state = LOAD;
      LOAD:    if (handshake && last_beat) next_state = FLUSH;
      FLUSH:                               next_state = COMPUTE;
      COMPUTE: if (compute_done)           next_state = IDLE;
      default:                             next_state = IDLE;
    endcase
  end

  // Handshake-facing outputs are registered from next_state, so s_ready drops
  // on the same edge that accepts the final sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      k          <= '0;
      n_q        <= N_W'(1);
      s_ready_q  <= 1'b0;
      ram_write  <= 1'b0;
      ram_adr    <= '0;
      ram_data   <= '0;
      mode       <= 1'b1;
      frame_done <= 1'b0;
      err_last   <= 1'b0;
    end else begin
      s_ready_q  <= (next_state == LOAD);
      mode       <= (next_state != COMPUTE);
      ram_write  <= handshake;
      frame_done <= handshake & last_beat;

      if (start_accept) begin
        n_q      <= N_W'(clamp_log2n(log2n, ADDR_W));
        k        <= '0;
        err_last <= 1'b0;
      end

      if (handshake) begin
        ram_data <= s.s_data;
        ram_adr  <= rev_adr;
        k        <= k + 1'b1;
        // The frame length is fixed by N; s_last is only cross-checked.
        if (s.s_last != last_beat) begin
          err_last <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fft_input_loader.sv
// Self-checking bench for fft_input_loader: randomized sample frames compared
// against a queue-based model of bit-reversed loading and RAM handoff.
module tb_fft_input_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  log2n;
  logic        compute_done;
  logic [15:0] ram_data;
  logic [11:0] ram_adr;
  logic        ram_write;
  logic        mode;
  logic        frame_done;
  logic        err_last;

  int checks   = 0;
  int failures = 0;

  logic [27:0] obs_q[$];

  fft_input_loader_if #(.DATA_W(16)) sif ();

  fft_input_loader dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .log2n        (log2n),
    .s            (sif.slave),
    .ram_data     (ram_data),
    .ram_adr      (ram_adr),
    .ram_write    (ram_write),
    .mode         (mode),
    .compute_done (compute_done),
    .frame_done   (frame_done),
    .err_last     (err_last)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ram_write === 1'b1) obs_q.push_back({ram_adr, ram_data});
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Reference bit reversal written straight from its definition.
  function automatic int brev(input int k, input int n);
    int r = 0;
    for (int b = 0; b < n; b++) begin
      if (((k >> b) & 1) == 1) r = r | (1 << (n - 1 - b));
    end
    return r;
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, ":s_ready"},    32'(sif.s_ready), 32'd0);
    check({tag, ":ram_write"},  32'(ram_write),   32'd0);
    check({tag, ":ram_adr"},    32'(ram_adr),     32'd0);
    check({tag, ":ram_data"},   32'(ram_data),    32'd0);
    check({tag, ":mode"},       32'(mode),        32'd1);
    check({tag, ":frame_done"}, 32'(frame_done),  32'd0);
    check({tag, ":err_last"},   32'(err_last),    32'd0);
  endtask

  task automatic arm(input int l2n, input string tag);
    sif.s_valid = 1'b0;
    start = 1'b1;
    log2n = 4'(l2n);
    @(negedge clk);
    start = 1'b0;
    check({tag, ":armed_ready"}, 32'(sif.s_ready), 32'd1);
    check({tag, ":armed_mode"},  32'(mode),        32'd1);
    check({tag, ":armed_err"},   32'(err_last),    32'd0);
  endtask

  // Drives one frame and compares every write, the gaps, and the handoff.
  task automatic send_frame(input int n_eff, input int last_at, input int valid_pct,
                            input logic [31:0] vpat, input int vpat_len,
                            input bit seq_data, input string tag);
    int          total = 1 << n_eff;
    int          idx = 0;
    int          cyc = 0;
    int          gap_bad = 0;
    int          bad = 0;
    bit          exp_err = 1'b0;
    bit          v;
    bit          hs;
    logic [27:0] exp_q[$];
    obs_q.delete();
    while (idx < total && cyc < total * 8 + 50) begin
      if (vpat_len > 0) v = (cyc < vpat_len) ? vpat[cyc] : 1'b1;
      else              v = ($urandom_range(99) < valid_pct);
      sif.s_valid = v;
      sif.s_data  = seq_data ? 16'(idx) : 16'($urandom);
      sif.s_last  = (idx == last_at);
      hs = v && (sif.s_ready === 1'b1);
      if (hs) begin
        exp_q.push_back({12'(brev(idx, n_eff)), sif.s_data});
        if ((idx == total - 1) != (idx == last_at)) exp_err = 1'b1;
        idx++;
      end
      @(negedge clk);
      cyc++;
      if (ram_write !== hs) gap_bad++;
    end
    sif.s_valid = 1'b0;
    sif.s_last  = 1'b0;
    check({tag, ":beats"}, 32'(idx), 32'(total));
    if (idx == total) begin
      check({tag, ":flush_done"},  32'(frame_done),   32'd1);
      check({tag, ":flush_mode"},  32'(mode),         32'd1);
      check({tag, ":flush_ready"}, 32'(sif.s_ready),  32'd0);
      @(negedge clk);
      check({tag, ":compute_mode"},  32'(mode),       32'd0);
      check({tag, ":compute_done0"}, 32'(frame_done), 32'd0);
      check({tag, ":compute_write"}, 32'(ram_write),  32'd0);
    end
    check({tag, ":write_gaps"}, 32'(gap_bad), 32'd0);
    check({tag, ":err_last"},   32'(err_last), 32'(exp_err));
    check({tag, ":n_writes"},   32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      if (obs_q[i] !== exp_q[i]) bad++;
    end
    check({tag, ":write_contents"}, 32'(bad), 32'd0);
    if (obs_q.size() > 0) begin
      check({tag, ":last_adr"}, 32'(obs_q[obs_q.size()-1][27:16]), 32'(total - 1));
    end
  endtask

  // Ignored start during COMPUTE, then the core's completion pulse.
  task automatic finish_compute(input bit with_start, input string tag);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, ":start_ignored"}, 32'(sif.s_ready), 32'd0);
    check({tag, ":still_compute"}, 32'(mode),        32'd0);
    compute_done = 1'b1;
    start = with_start;
    @(negedge clk);
    compute_done = 1'b0;
    start = 1'b0;
    check({tag, ":returned_mode"}, 32'(mode),        32'd1);
    check({tag, ":idle_ready"},    32'(sif.s_ready), 32'd0);
    @(negedge clk);
    check({tag, ":idle_hold"},     32'(sif.s_ready), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    log2n = '0;
    compute_done = 1'b0;
    sif.s_valid = 1'b0;
    sif.s_data = '0;
    sif.s_last = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals("por");
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", 32'(sif.s_ready), 32'd0);

    arm(3, "brev8");
    send_frame(3, 7, 100, 32'd0, 0, 1'b1, "brev8");
    finish_compute(1'b0, "brev8");

    arm(2, "gaps");
    send_frame(2, 3, 0, 32'b1011001, 7, 1'b0, "gaps");
    finish_compute(1'b1, "gaps");

    arm(3, "framing");
    send_frame(3, 2, 70, 32'd0, 0, 1'b0, "framing");
    finish_compute(1'b0, "framing");
    arm(3, "framing_clear");
    send_frame(3, 7, 60, 32'd0, 0, 1'b0, "framing_clear");
    finish_compute(1'b0, "framing_clear");

    arm(4, "midreset");
    for (int i = 0; i < 5; i++) begin
      sif.s_valid = 1'b1;
      sif.s_data  = 16'($urandom);
      sif.s_last  = 1'b0;
      @(negedge clk);
    end
    sif.s_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("midreset");
    rst = 1'b0;
    @(negedge clk);
    arm(4, "after_reset");
    send_frame(4, 15, 80, 32'd0, 0, 1'b0, "after_reset");
    finish_compute(1'b0, "after_reset");

    arm(15, "clamp_hi");
    send_frame(12, 4095, 100, 32'd0, 0, 1'b0, "clamp_hi");
    finish_compute(1'b0, "clamp_hi");

    arm(0, "clamp_lo");
    send_frame(1, 1, 100, 32'd0, 0, 1'b0, "clamp_lo");
    if (obs_q.size() == 2) begin
      check("clamp_lo:adr0", 32'(obs_q[0][27:16]), 32'd0);
      check("clamp_lo:adr1", 32'(obs_q[1][27:16]), 32'd1);
    end
    finish_compute(1'b0, "clamp_lo");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fft_input_loader.md
# fft_input_loader

Streaming front end of the FFT datapath: accepts 16-bit time-domain samples over a valid/ready stream and writes them into the FFT sample RAM in bit-reversed address order, so the compute core can run in-place butterflies directly. It owns the RAM's load-side write port (16-bit data, 12-bit address, write strobe) and drives the RAM `mode` select. It holds `mode` at 1 while loading, hands the RAM to the compute core (`mode` = 0) once a frame is complete, and takes it back when the core reports completion.

## Interface
Parameters:
- `ADDR_W`, 12, RAM address width; maximum frame size is 2^ADDR_W.
- `DATA_W`, 16, sample width.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `start`  in  1  one-cycle request to arm a new frame; honoured only in IDLE.
- `log2n`  in  4  frame size exponent, sampled on the accepted `start`. Value 0 is treated as 1; values above ADDR_W are treated as ADDR_W.
- `s_data`  in  DATA_W  sample payload.
- `s_valid`  in  1  sample present.
- `s_ready`  out  1  loader accepts a sample.
- `s_last`  in  1  producer's end-of-frame marker; checked only, never used for control.
- `ram_data`  out  DATA_W  write data to RAM.
- `ram_adr`  out  ADDR_W  bit-reversed write address.
- `ram_write`  out  1  RAM write strobe.
- `mode`  out  1  RAM ownership: 1 = loader, 0 = compute core.
- `compute_done`  in  1  one-cycle pulse from the core; returns the RAM to the loader.
- `frame_done`  out  1  one-cycle pulse when the last write of a frame is issued.
- `err_last`  out  1  sticky framing error flag; cleared by an accepted `start`.

## Operation
- **States:** IDLE, LOAD, FLUSH, COMPUTE.
- **IDLE**
  - `mode` = 1, `s_ready` = 0.
  - An accepted `start` latches N = 2^log2n (after clamping), clears the counter and `err_last`, and moves to LOAD.
- **LOAD**
  - `s_ready` = 1.
  - Each handshake (`s_valid` & `s_ready`) with counter k registers `ram_data` = `s_data`, `ram_adr` = bitrev_n(k), and `ram_write` = 1, then increments k.
  - bitrev_n(k) reverses the low n bits of k, with the upper bits at 0. Equivalently, it is reverse_ADDR_W(k) >> (ADDR_W − n).
  - On the handshake with k = N−1, move to FLUSH and drop `s_ready` in the same edge.
- **FLUSH** lasts one cycle:
  - The final `ram_write` is presented with `mode` still at 1.
  - `frame_done` pulses.
  - The next state is COMPUTE.
- **COMPUTE**
  - `mode` = 0, `s_ready` = 0, `ram_write` = 0.
  - On `compute_done`, go to IDLE.
- **Framing check:**
  - `s_last` = 1 on a beat with k ≠ N−1 sets `err_last`.
  - `s_last` = 0 on the beat with k = N−1 also sets `err_last`.
  - The frame length is always N regardless of `s_last`.
- **Simultaneous or ignored inputs:**
  - `start` outside IDLE is ignored.
  - `compute_done` outside COMPUTE is ignored.
  - `start` and `compute_done` arriving together in COMPUTE: only the transition to IDLE happens; that `start` is not honoured.
- **Reset:** `rst` in any state, including mid-LOAD, returns to IDLE with k = 0. RAM contents already written are undefined for the next frame.

## Timing
- **Reset values:** `s_ready` 0, `ram_write` 0, `ram_adr` 0, `ram_data` 0, `mode` 1, `frame_done` 0, `err_last` 0.
- **Outputs:** all are registered; there are no combinational input-to-output paths.
- **Accepting `start`:** `start` at edge t gives `s_ready` = 1 from t+1.
- **Write latency:** a handshake at edge t produces `ram_write`/`ram_adr`/`ram_data` valid during cycle t+1. Throughput is one sample per clock.
- **Stalls:** with `s_valid` = 0, `ram_write` is 0 in the following cycle and k holds.
- **Last sample:** a handshake of the last sample at edge t gives:
  - `ram_write` = 1 and `frame_done` = 1 during t+1 (FLUSH), with `mode` = 1;
  - `mode` = 0 from t+2.
- **Returning the RAM:** `compute_done` at edge t gives `mode` = 1 from t+1, back in IDLE.
- **Minimum frame cycle** is N + 3 clocks plus compute time.

## Structure
- **Shared package `fft_pkg`** holds:
  - `FFT_ADDR_W` = 12 and `FFT_SAMPLE_W` = 16;
  - the loader state enum `loader_state_t` {IDLE, LOAD, FLUSH, COMPUTE};
  - the log2n clamp helper function.
- **Sub-module `bit_rev`**: combinational, parameter `ADDR_W`. Inputs are the count and n; the output is the reversed address.
- **Top level** contains the FSM, counter, output registers and the error flag.

## Test plan
- **Bit-reversed addressing:** `log2n` = 3, `start`, then samples 0..7 back-to-back with `s_last` on the 8th → writes to addresses 0,4,2,6,1,5,3,7 with data 0..7. `frame_done` occurs one cycle after the 8th handshake, `mode` = 0 the cycle after that, and `err_last` = 0.
- **Backpressure and gaps:** `log2n` = 2 with `s_valid` toggling 1,0,0,1,1,0,1 → exactly 4 writes to 0,2,1,3, and no `ram_write` in the gap cycles.
- **Framing error:** `log2n` = 3 with `s_last` on the 3rd beat → `err_last` = 1 from the next cycle and 8 writes still performed. A later `start` clears `err_last`.
- **Ownership handoff:** `start` pulsed during COMPUTE → ignored (`s_ready` stays 0). `compute_done` → `mode` = 1 and IDLE; a following `start` arms a new frame.
- **Reset mid-load:** `rst` after 5 of 16 samples → all outputs at reset values next cycle. A new `start` with `log2n` = 4 begins at address 0.
- **Clamping:** `log2n` = 15 → a 4096-sample frame whose last write goes to address 4095 (k = 4095). `log2n` = 0 → a 2-sample frame with addresses 0, 1.
